// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) feeding the HI/LO write path.
// One shift-add or restoring shift-subtract step per clock, then a sign-fixup cycle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_next;
    logic               is_div;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   a_orig, b_mag;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [CNT_W-1:0]   cnt;

    logic               in_sign_a, in_sign_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               last_iter;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Operand conditioning: op[0]=0 selects the signed variants.
    always_comb begin
        in_sign_a = ~op[0] & op_a[WIDTH-1];
        in_sign_b = ~op[0] & op_b[WIDTH-1];
        in_mag_a  = in_sign_a ? -op_a : op_a;
        in_mag_b  = in_sign_b ? -op_b : op_b;
    end

    // acc = {partial product | remainder, multiplier bits | dividend/quotient bits}
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_mag};
        if (is_div) begin
            if (rem_diff[WIDTH]) acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else                 acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_mag == '0) begin
                fix_hi = a_orig;
                fix_lo = '1;
            end else begin
                // Most-negative / -1 wraps back to itself through the negate.
                fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            a_orig      <= '0;
            b_mag       <= '0;
            acc         <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div      <= op[1];
                        sign_a      <= in_sign_a;
                        sign_b      <= in_sign_b;
                        a_orig      <= op_a;
                        b_mag       <= in_mag_b;
                        acc         <= {{WIDTH{1'b0}}, in_mag_a};
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    done        <= 1'b1;
                    div_by_zero <= is_div & (b_mag == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    // Returns {div_by_zero, hi, lo}.
    function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [63:0] pu;
        int          sa, sb, q, r;
        case (o)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return {1'b0, 64'(p)};
            end
            2'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                return {1'b0, pu};
            end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, 32'h80000000};
                sa = a; sb = b;
                q = sa / sb; r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0; busy_ok = 1'b1;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
        logic [31:0] t_a  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'h1234};
        logic [31:0] t_b  [6] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
        logic [64:0] t_exp[6] = '{{1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB},
                                  {1'b0, 32'hFFFFFFFE, 32'h00000001},
                                  {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD},
                                  {1'b0, 32'd2, 32'd14},
                                  {1'b0, 32'd0, 32'h80000000},
                                  {1'b1, 32'h1234, 32'hFFFFFFFF}};
        int lat; bit busy_ok;
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(lat, busy_ok);
            vectors++; if (lat !== 33) begin miscompares++; $display("FAIL directed%0d_latency got %0d want 33", i, lat); end
            vectors++; if (!busy_ok || busy !== 1'b0) begin miscompares++; $display("FAIL directed%0d_busy got busy_ok=%b busy_at_done=%b want 1/0", i, busy_ok, busy); end
            vectors++;
            if ({div_by_zero, hi, lo} !== t_exp[i]) begin
                miscompares++;
                $display("FAIL directed%0d_result got dz=%b hi=%h lo=%h want %h", i, div_by_zero, hi, lo, t_exp[i]);
            end
            repeat (3) @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b0 || {div_by_zero, hi, lo} !== t_exp[i]) begin
                miscompares++;
                $display("FAIL directed%0d_hold got done=%b dz=%b hi=%h lo=%h want done=0 %h", i, done, div_by_zero, hi, lo, t_exp[i]);
            end
        end
    endtask

    task automatic test_dz_clear();
        int lat; bit busy_ok;
        vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dz_held got %b want 1", div_by_zero); end
        issue(2'd3, 32'd100, 32'd7);
        vectors++; if (div_by_zero !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL dz_clear got dz=%b busy=%b want 0/1", div_by_zero, busy); end
        wait_done(lat, busy_ok);
        vectors++; if ({div_by_zero, hi, lo} !== {1'b0, 32'd2, 32'd14}) begin miscompares++; $display("FAIL dz_clear_result got dz=%b hi=%h lo=%h want 0/2/14", div_by_zero, hi, lo); end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b, prev_hi, prev_lo;
        logic [64:0] exp;
        int lat; bit busy_ok;
        a = $urandom; b = $urandom;
        prev_hi = hi; prev_lo = lo;
        exp = ref_model(2'd0, a, b);
        issue(2'd0, a, b);
        repeat (9) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ignore_busy got %b want 1", busy); end
        start = 1'b1; op = 2'd3; op_a = ~a; op_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (hi !== prev_hi || lo !== prev_lo) begin miscompares++; $display("FAIL ignore_stable got hi=%h lo=%h want %h %h", hi, lo, prev_hi, prev_lo); end
        wait_done(lat, busy_ok);
        vectors++; if (lat + 10 !== 33) begin miscompares++; $display("FAIL ignore_latency got %0d want 33", lat + 10); end
        vectors++; if ({div_by_zero, hi, lo} !== exp) begin miscompares++; $display("FAIL ignore_result got dz=%b hi=%h lo=%h want %h", div_by_zero, hi, lo, exp); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [64:0] exp;
        int lat; bit busy_ok;
        o = 2'($urandom); a = rand_operand(); b = rand_operand();
        exp = ref_model(o, a, b);
        issue(o, a, b);
        wait_done(lat, busy_ok);
        for (int i = 0; i < 4; i++) begin
            vectors++; if ({div_by_zero, hi, lo} !== exp) begin miscompares++; $display("FAIL b2b%0d_result op=%0d a=%h b=%h got dz=%b hi=%h lo=%h want %h", i, o, a, b, div_by_zero, hi, lo, exp); end
            o = 2'($urandom); a = rand_operand(); b = rand_operand();
            exp = ref_model(o, a, b);
            issue(o, a, b);
            vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL b2b%0d_restart got busy=%b done=%b want 1/0", i, busy, done); end
            wait_done(lat, busy_ok);
            vectors++; if (lat !== 33 || !busy_ok) begin miscompares++; $display("FAIL b2b%0d_latency got %0d busy_ok=%b want 33/1", i, lat, busy_ok); end
        end
        vectors++; if ({div_by_zero, hi, lo} !== exp) begin miscompares++; $display("FAIL b2b_last_result got dz=%b hi=%h lo=%h want %h", div_by_zero, hi, lo, exp); end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [64:0] exp;
        int lat; bit busy_ok;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom); a = rand_operand(); b = rand_operand();
            exp = ref_model(o, a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(o, a, b);
            wait_done(lat, busy_ok);
            vectors++; if (lat !== 33 || !busy_ok) begin miscompares++; $display("FAIL rand%0d_latency got %0d busy_ok=%b want 33/1", i, lat, busy_ok); end
            vectors++;
            if ({div_by_zero, hi, lo} !== exp) begin
                miscompares++;
                $display("FAIL rand%0d_result op=%0d a=%h b=%h got dz=%b hi=%h lo=%h want %h", i, o, a, b, div_by_zero, hi, lo, exp);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        issue(2'd0, $urandom | 32'h1, $urandom | 32'h1);
        repeat (15) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_ctrl got busy=%b done=%b want 0/0", busy, done); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin miscompares++; $display("FAIL abort_hilo got hi=%h lo=%h want 0/0", hi, lo); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got done pulse want none"); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_dz_clear();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
